if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding bus request, registered IF/ID offer, redirect squashing.
// Optional performance counters are enabled with the IF_PERF_COUNTERS_EN macro.
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StValid, StDrop} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] pend_pc_q;
  logic [63:0] target;
  logic [63:0] pc_inc;
  logic [63:0] drop_next;

  assign target    = redirect_pc & ~64'h3;
  assign pc_inc    = pc_q + 64'd4;
  // A redirect arriving together with the dropped ack wins over the older pending target.
  assign drop_next = redirect_valid ? target : pend_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pend_pc_q <= 64'h0;
      if_req    <= 1'b0;
      if_addr   <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= 64'h0;
      out_inst  <= 32'h0000_0013;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          if_req  <= 1'b1;
          if (redirect_valid) begin
            pc_q    <= target;
            if_addr <= target;
          end else begin
            if_addr <= pc_q;
          end
        end
        StReq: begin
          if (if_ack) begin
            if (redirect_valid) begin
              // Returned word belongs to the squashed path; reissue at the target.
              pc_q    <= target;
              if_addr <= target;
            end else begin
              out_valid <= 1'b1;
              out_pc    <= pc_q;
              out_inst  <= if_rdata;
              if_req    <= 1'b0;
              state_q   <= StValid;
            end
          end else if (redirect_valid) begin
            pend_pc_q <= target;
            state_q   <= StDrop;
          end
        end
        StValid: begin
          if (redirect_valid) begin
            pc_q      <= target;
            if_addr   <= target;
            if_req    <= 1'b1;
            out_valid <= 1'b0;
            state_q   <= StReq;
          end else if (!hold) begin
            pc_q      <= pc_inc;
            if_addr   <= pc_inc;
            if_req    <= 1'b1;
            out_valid <= 1'b0;
            state_q   <= StReq;
          end
        end
        StDrop: begin
          if (if_ack) begin
            pc_q    <= drop_next;
            if_addr <= drop_next;
            state_q <= StReq;
          end else if (redirect_valid) begin
            pend_pc_q <= target;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 64'h0;
      stall_cnt_q <= 64'h0;
    end else if (out_valid && !redirect_valid) begin
      if (hold) stall_cnt_q <= stall_cnt_q + 64'd1;
      else      fetch_cnt_q <= fetch_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 64'h0;
  assign perf_stall_cnt = 64'h0;
`endif

endmodule
